// File: rtl/noc_flit_pkg.sv
// Shared flit format for the packet splitter and collector: field widths,
// bit offsets and the splitter FSM state type.
package noc_flit_pkg;

  localparam int SLICE_W = 17;
  localparam int SLICES  = 4;
  localparam int PKT_W   = 68;
  localparam int BIDX_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } split_state_t;

  function automatic int node_w(input int node_count);
    return (node_count > 1) ? $clog2(node_count) : 1;
  endfunction

  function automatic int flit_w(input int node_count, input int id_w);
    return 1 + 2 * node_w(node_count) + id_w + SLICE_W + BIDX_W;
  endfunction

  // Offsets of each field's LSB, LSB-first: byte_index, node_start, packet_id, data, node_dest, valid
  function automatic int start_lsb();
    return BIDX_W;
  endfunction

  function automatic int id_lsb(input int node_count);
    return BIDX_W + node_w(node_count);
  endfunction

  function automatic int data_lsb(input int node_count, input int id_w);
    return id_lsb(node_count) + id_w;
  endfunction

  function automatic int dest_lsb(input int node_count, input int id_w);
    return data_lsb(node_count, id_w) + SLICE_W;
  endfunction

  function automatic int valid_bit(input int node_count, input int id_w);
    return dest_lsb(node_count, id_w) + node_w(node_count);
  endfunction

endpackage

// File: rtl/packet_splitter_fifo.sv
// Synchronous packet FIFO with full/empty/count; push and pop only act when ce is high.
module packet_fifo #(
  parameter  int WIDTH = 71,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_push = ce && push && !full;
  assign do_pop  = ce && pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_splitter.sv
// Buffers 68-bit packets, tags them with source node and rolling packet_id,
// and serialises each into four flits for the network.
module packet_splitter
  import noc_flit_pkg::*;
#(
  parameter  int NODE_COUNT      = 8,
  parameter  int PACKET_ID_WIDTH = 5,
  parameter  int FIFO_DEPTH      = 4,
  localparam int NODE_W          = node_w(NODE_COUNT),
  localparam int FLIT_W          = flit_w(NODE_COUNT, PACKET_ID_WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [NODE_W-1:0] node_id,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [PKT_W-1:0]  pkt_data,
  input  logic [NODE_W-1:0] pkt_dest,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              busy
);

  localparam int ENTRY_W = PKT_W + NODE_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ID_LSB  = id_lsb(NODE_COUNT);
  localparam int DAT_LSB = data_lsb(NODE_COUNT, PACKET_ID_WIDTH);
  localparam int DST_LSB = dest_lsb(NODE_COUNT, PACKET_ID_WIDTH);
  localparam int VLD_BIT = valid_bit(NODE_COUNT, PACKET_ID_WIDTH);
  localparam int STR_LSB = start_lsb();

  split_state_t               state;
  split_state_t               next_state;
  logic [ENTRY_W-1:0]         head;
  logic                       full;
  logic                       empty;
  logic [CNT_W-1:0]           count;
  logic                       load;
  logic                       step;
  logic [PKT_W-1:0]           shift;
  logic [NODE_W-1:0]          dest;
  logic [NODE_W-1:0]          start;
  logic [PACKET_ID_WIDTH-1:0] pkt_id;
  logic [PACKET_ID_WIDTH-1:0] id_cnt;
  logic [BIDX_W-1:0]          byte_idx;

  packet_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .push  (pkt_valid),
    .din   ({pkt_data, pkt_dest}),
    .pop   (load),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign pkt_ready  = !full;
  assign flit_valid = (state == ST_SEND);
  assign busy       = (count != {CNT_W{1'b0}}) || (state == ST_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ce && !empty) next_state = ST_SEND;
        else              next_state = ST_IDLE;
      end
      ST_SEND: begin
        if (ce && flit_ready && (byte_idx == 2'd3) && empty) next_state = ST_IDLE;
        else                                                 next_state = ST_SEND;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // load pops the next packet (also back-to-back after the last flit); step advances the slice
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ce && !empty) load = 1'b1;
        else              load = 1'b0;
      end
      ST_SEND: begin
        if (ce && flit_ready) begin
          if (byte_idx == 2'd3) load = !empty;
          else                  step = 1'b1;
        end else begin
          load = 1'b0;
          step = 1'b0;
        end
      end
      default: begin
        load = 1'b0;
        step = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= {PKT_W{1'b0}};
      dest     <= {NODE_W{1'b0}};
      start    <= {NODE_W{1'b0}};
      pkt_id   <= {PACKET_ID_WIDTH{1'b0}};
      id_cnt   <= {PACKET_ID_WIDTH{1'b0}};
      byte_idx <= 2'd0;
    end else if (load) begin
      shift    <= head[ENTRY_W-1 -: PKT_W];
      dest     <= head[NODE_W-1:0];
      start    <= node_id;
      pkt_id   <= id_cnt;
      id_cnt   <= id_cnt + PACKET_ID_WIDTH'(1);
      byte_idx <= 2'd0;
    end else if (step) begin
      shift    <= {shift[PKT_W-SLICE_W-1:0], {SLICE_W{1'b0}}};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Flit is assembled purely from registers and forced to zero when not valid
  always_comb begin
    flit_out = {FLIT_W{1'b0}};
    if (state == ST_SEND) begin
      flit_out[VLD_BIT]                     = 1'b1;
      flit_out[DST_LSB +: NODE_W]           = dest;
      flit_out[DAT_LSB +: SLICE_W]          = shift[PKT_W-1 -: SLICE_W];
      flit_out[ID_LSB +: PACKET_ID_WIDTH]   = pkt_id;
      flit_out[STR_LSB +: NODE_W]           = start;
      flit_out[BIDX_W-1:0]                  = byte_idx;
    end else begin
      flit_out = {FLIT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_packet_splitter.sv
// Scoreboard bench for packet_splitter: stimulus queues expected flits,
// a negedge monitor compares every presented flit against the queue head.
module tb_packet_splitter;

  localparam logic [2:0] SELF = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [2:0]  node_id;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [67:0] pkt_data;
  logic [2:0]  pkt_dest;
  logic [30:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [30:0] exp_q[$];
  logic [4:0]  model_id;

  always #5 clk = ~clk;

  packet_splitter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .node_id    (node_id),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .pkt_dest   (pkt_dest),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Layout: valid | dest(3) | data(17) | packet_id(5) | node_start(3) | byte_index(2)
  function automatic logic [30:0] exp_flit(input logic [67:0] d, input logic [2:0] dst,
                                           input logic [4:0] pid, input int k);
    logic [16:0] s;
    s = d[67-17*k -: 17];
    return {1'b1, dst, s, pid, SELF, 2'(k)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (flit_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_flit got=%h want=none at %0t", flit_out, $time);
        end else begin
          check("flit", 64'(flit_out), 64'(exp_q[0]));
          if (ce && flit_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_zero", 64'(flit_out), 64'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push_pkt(input logic [67:0] d, input logic [2:0] dst);
    bit acc;
    bit done;
    done      = 1'b0;
    pkt_valid = 1'b1;
    pkt_data  = d;
    pkt_dest  = dst;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      acc = pkt_ready && ce && rst_n;
      @(posedge clk);
      if (acc) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_flit(d, dst, model_id, k));
        model_id = model_id + 5'd1;
        done = 1'b1;
      end
      #1;
    end
    pkt_valid = 1'b0;
    if (!done) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && !flit_valid) done = 1'b1;
    end
    check("idle_reached", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    ce         = 1'b1;
    node_id    = SELF;
    pkt_valid  = 1'b0;
    pkt_data   = 68'd0;
    pkt_dest   = 3'd0;
    flit_ready = 1'b1;
    model_id   = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flit_valid", 64'(flit_valid), 64'd0);
    check("rst_flit_out", 64'(flit_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pkt_ready", 64'(pkt_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single packet, one-cycle latency to flit 0
    push_pkt(68'h0_1234_5678_9ABC_DEF0, 3'd3);
    check("lat_not_yet", 64'(flit_valid), 64'd0);
    check("lat_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("lat_flit0_valid", 64'(flit_valid), 64'd1);
    check("lat_flit0_idx", 64'(flit_out[1:0]), 64'd0);
    wait_idle();
    check("single_busy_low", 64'(busy), 64'd0);

    // Backpressure during flit 1
    push_pkt(68'hA_BCDE_F012_3456_789A, 3'd6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flit_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_idx", 64'(flit_out[1:0]), 64'd1);
    flit_ready = 1'b1;
    wait_idle();

    // Back-to-back: one packet in SEND plus four queued fills the FIFO
    flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pkt({4'(i), 64'h1111_2222_3333_4444 * 64'(i + 1)}, 3'(i));
    check("b2b_full_ready", 64'(pkt_ready), 64'd0);
    flit_ready = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    check("b2b_last_flit", 64'(flit_valid), 64'd1);
    @(posedge clk);
    #1;
    check("b2b_drained", 64'(flit_valid), 64'd0);
    wait_idle();

    // Packet id wrap: 7 packets so far, 30 more passes 32
    for (int i = 0; i < 30; i++) push_pkt({4'hC, 32'h1357_9BDF ^ 32'(i * 7), 32'hA5A5_0000 + 32'(i)}, 3'(i % 8));
    wait_idle();

    // ce stall mid-packet with a packet offered
    push_pkt(68'h5_5555_AAAA_5555_AAAA, 3'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ce        = 1'b0;
    pkt_valid = 1'b1;
    pkt_data  = 68'hF_FFFF_0000_FFFF_0000;
    pkt_dest  = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    check("ce_hold_idx", 64'(flit_out[1:0]), 64'd1);
    check("ce_hold_valid", 64'(flit_valid), 64'd1);
    ce        = 1'b1;
    pkt_valid = 1'b0;
    wait_idle();

    // Reset during flit 2 with two packets queued
    flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pkt({4'h9, 64'hDEAD_BEEF_0000_0000 + 64'(i)}, 3'd2);
    flit_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_idx", 64'(flit_out[1:0]), 64'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(flit_valid), 64'd0);
    check("rst_mid_flit", 64'(flit_out), 64'd0);
    exp_q.delete();
    model_id = 5'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_ready", 64'(pkt_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    push_pkt(68'h3_0F0F_F0F0_1234_4321, 3'd4);
    wait_idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
